nlprg15_chk: RTL and testbench

Receive-side sequence checker for the 15-bit nonlinear pseudo-random generator output `o[14:0]`. The block sits at the far end of a PRNG link, such as a loopback, serial link or BIST path. It locks onto the incoming word stream by self-seeding, then predicts every following word. It counts mismatches and verifies the full 2^15 period by checking that the zero state recurs exactly every 32768 words. This is the checking counterpart of the generator and replaces bench-only period checking with synthesizable logic.

---
 rtl/nlprg15_pkg.sv | 20 ++
 rtl/nlprg15_chk_if.sv | 26 ++
 rtl/nlprg15_period_mon.sv | 57 +++++
 rtl/nlprg15_chk.sv | 114 +++++++++++
 tb/tb_nlprg15_chk.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/nlprg15_pkg.sv
// Shared definitions for the 15-bit nonlinear PRNG and its receive-side checker.
// nxt() is the single definition of the sequence used by both ends of the link.
package nlprg15_pkg;

    localparam int N      = 15;
    localparam int PERIOD = 32768;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // x^15+x^14+1 LFSR step, with the feedback inverted when s[13:0] is zero.
    // This splices the all-zero state into the cycle, which gives a full 2^15 period.
    function automatic logic [N-1:0] nxt(input logic [N-1:0] s);
        return {s[N-2:0], s[N-1] ^ s[N-2] ^ (s[N-2:0] == '0)};
    endfunction

endpackage

// File: rtl/nlprg15_chk_if.sv
// Word stream and status bundle between a PRNG link receiver and nlprg15_chk.
interface nlprg15_chk_if #(
    parameter int N     = 15,
    parameter int ERR_W = 16
) ();

    logic             vld;
    logic [N-1:0]     d;
    logic             lock;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             wrap;
    logic             period_ok;
    logic             period_bad;

    modport master (
        output vld, d,
        input  lock, err, err_cnt, wrap, period_ok, period_bad
    );

    modport slave (
        input  vld, d,
        output lock, err, err_cnt, wrap, period_ok, period_bad
    );

endinterface

// File: rtl/nlprg15_period_mon.sv
// Zero-word spacing monitor: while locked, checks that zero words recur
// exactly one PRNG period apart.
module nlprg15_period_mon
    import nlprg15_pkg::*;
(
    input  logic ck,
    input  logic rst,
    input  logic vld,
    input  logic is_zero,
    input  logic locked,
    input  logic start,
    output logic wrap,
    output logic period_ok,
    output logic period_bad
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] word_cnt;
    logic [CW-1:0] cnt_inc;
    logic          zero_seen;

    assign cnt_inc = word_cnt + CW'(1);

    // The counter restarts at every zero, so a full period makes the increment wrap to 0 exactly on the next zero.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            word_cnt   <= '0;
            zero_seen  <= 1'b0;
            wrap       <= 1'b0;
            period_ok  <= 1'b0;
            period_bad <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (start) begin
                word_cnt  <= '0;
                zero_seen <= 1'b0;
            end else if (vld && locked) begin
                if (is_zero) begin
                    wrap      <= 1'b1;
                    zero_seen <= 1'b1;
                    word_cnt  <= '0;
                    if (zero_seen) begin
                        if (cnt_inc == '0) begin
                            period_ok <= 1'b1;
                        end else begin
                            period_bad <= 1'b1;
                        end
                    end
                end else begin
                    word_cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: rtl/nlprg15_chk.sv
// Receive-side checker for the nlprg15 word stream. It self-seeds from the data,
// locks after a run of correct predictions, then counts mismatches and checks the period.
module nlprg15_chk #(
    parameter int N        = 15,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic         ck,
    input  logic         rst,
    nlprg15_chk_if.slave bus
);

    import nlprg15_pkg::*;

    chk_state_t       state, state_n;
    logic [N-1:0]     pred, pred_n;
    logic [7:0]       match_cnt, match_n;
    logic [7:0]       miss_cnt, miss_n;
    logic             err_q, err_n;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_n;
    logic             enter_lock;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            pred      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            err_q     <= err_n;
            err_cnt_q <= err_cnt_n;
        end
    end

    // Once locked, the prediction runs free and is never reseeded from d,
    // so a slipped or dropped word shows up as a run of misses.
    always_comb begin
        state_n    = state;
        pred_n     = pred;
        match_n    = match_cnt;
        miss_n     = miss_cnt;
        err_n      = 1'b0;
        err_cnt_n  = err_cnt_q;
        enter_lock = 1'b0;
        if (bus.vld) begin
            case (state)
                HUNT: begin
                    pred_n  = nxt(bus.d);
                    match_n = '0;
                    state_n = VERIFY;
                end
                VERIFY: begin
                    if (bus.d == pred) begin
                        pred_n = nxt(pred);
                        if (match_cnt + 8'd1 == 8'(LOCK_CNT)) begin
                            match_n    = '0;
                            state_n    = LOCKED;
                            enter_lock = 1'b1;
                        end else begin
                            match_n = match_cnt + 8'd1;
                        end
                    end else begin
                        pred_n  = nxt(bus.d);
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    pred_n = nxt(pred);
                    if (bus.d != pred) begin
                        err_n = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_n = err_cnt_q + ERR_W'(1);
                        end
                        if (miss_cnt + 8'd1 == 8'(LOSS_CNT)) begin
                            miss_n  = '0;
                            state_n = HUNT;
                        end else begin
                            miss_n = miss_cnt + 8'd1;
                        end
                    end else begin
                        miss_n = '0;
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    assign bus.lock    = (state == LOCKED);
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

    nlprg15_period_mon u_period_mon (
        .ck         (ck),
        .rst        (rst),
        .vld        (bus.vld),
        .is_zero    (bus.d == '0),
        .locked     (state == LOCKED),
        .start      (enter_lock),
        .wrap       (bus.wrap),
        .period_ok  (bus.period_ok),
        .period_bad (bus.period_bad)
    );

endmodule

// File: tb/tb_nlprg15_chk.sv
// Scoreboard bench for nlprg15_chk: stimulus pushes the expected response of each
// word and a monitor pops and compares it after the accepting edge.
module tb_nlprg15_chk;

    typedef struct {
        logic        lock;
        logic        err;
        logic        wrap;
        logic [15:0] cnt;
        logic        pok;
        logic        pbad;
    } exp_t;

    logic ck;
    logic rst;

    nlprg15_chk_if #(.N(15), .ERR_W(16)) bus ();

    nlprg15_chk #(
        .N        (15),
        .LOCK_CNT (8),
        .LOSS_CNT (4),
        .ERR_W    (16)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [14:0] g;
    logic [15:0] exp_cnt;
    logic        exp_pok;
    logic        exp_pbad;
    logic        lk_prev;

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Sequence generator written independently from the spec's next-state rule.
    function automatic logic [14:0] gen_next(input logic [14:0] s);
        logic fb;
        fb = s[14] ^ s[13];
        if (s[13:0] == 14'd0) fb = ~fb;
        return {s[13:0], fb};
    endfunction

    function automatic logic [14:0] gen_prev(input logic [14:0] t);
        logic [14:0] s;
        s[13:0] = t[14:1];
        s[14]   = t[0] ^ t[14] ^ (t[14:1] == 14'd0);
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] w, input logic e_lock, input logic e_err);
        exp_t e;
        @(posedge ck);
        #1;
        bus.vld = 1'b1;
        bus.d   = w;
        e.lock  = e_lock;
        e.err   = e_err;
        e.wrap  = lk_prev && (w == 15'd0);
        e.cnt   = exp_cnt;
        e.pok   = exp_pok;
        e.pbad  = exp_pbad;
        sb.push_back(e);
        lk_prev = e_lock;
    endtask

    task automatic send_gen(input logic e_lock);
        logic [14:0] w;
        w = g;
        g = gen_next(g);
        applyStimulus(w, e_lock, 1'b0);
    endtask

    task automatic send_bad(input logic [14:0] w, input logic e_lock);
        exp_cnt = exp_cnt + 16'd1;
        g = gen_next(g);
        applyStimulus(w, e_lock, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
            bus.vld = 1'b0;
        end
    endtask

    task automatic reset_check(input string tag);
        checkOutput({tag, "_lock"},       {31'd0, bus.lock},       32'd0);
        checkOutput({tag, "_err"},        {31'd0, bus.err},        32'd0);
        checkOutput({tag, "_err_cnt"},    {16'd0, bus.err_cnt},    32'd0);
        checkOutput({tag, "_wrap"},       {31'd0, bus.wrap},       32'd0);
        checkOutput({tag, "_period_ok"},  {31'd0, bus.period_ok},  32'd0);
        checkOutput({tag, "_period_bad"}, {31'd0, bus.period_bad}, 32'd0);
    endtask

    // Reset is raised between clock edges and the outputs are checked before any edge follows.
    task automatic pulse_reset(input string tag);
        @(posedge ck);
        #1;
        bus.vld = 1'b0;
        @(negedge ck);
        #2;
        rst = 1'b1;
        #1;
        reset_check(tag);
        @(negedge ck);
        rst      = 1'b0;
        exp_cnt  = 16'd0;
        exp_pok  = 1'b0;
        exp_pbad = 1'b0;
        lk_prev  = 1'b0;
    endtask

    // Monitor: one expected record per accepted word; err/wrap must be low on idle cycles.
    initial begin
        exp_t e;
        bit   acc;
        forever begin
            @(posedge ck);
            acc = bus.vld && !rst;
            @(negedge ck);
            if (acc) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb_underflow: got an accepted word, expected none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    checkOutput("lock",       {31'd0, bus.lock},       {31'd0, e.lock});
                    checkOutput("err",        {31'd0, bus.err},        {31'd0, e.err});
                    checkOutput("wrap",       {31'd0, bus.wrap},       {31'd0, e.wrap});
                    checkOutput("err_cnt",    {16'd0, bus.err_cnt},    {16'd0, e.cnt});
                    checkOutput("period_ok",  {31'd0, bus.period_ok},  {31'd0, e.pok});
                    checkOutput("period_bad", {31'd0, bus.period_bad}, {31'd0, e.pbad});
                end
            end else if (!rst) begin
                checkOutput("err_idle",  {31'd0, bus.err},  32'd0);
                checkOutput("wrap_idle", {31'd0, bus.wrap}, 32'd0);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        bus.vld  = 1'b0;
        bus.d    = '0;
        exp_cnt  = 16'd0;
        exp_pok  = 1'b0;
        exp_pbad = 1'b0;
        lk_prev  = 1'b0;
        g        = 15'd0;
        #2;
        reset_check("por");
        repeat (2) @(negedge ck);
        rst = 1'b0;

        $display("[TB] clean lock from zero, single error, loss and re-lock");
        for (int i = 0; i < 14; i++) send_gen(i >= 8);
        send_bad(15'd0, 1'b1);
        for (int i = 0; i < 5; i++) send_gen(1'b1);
        for (int i = 0; i < 4; i++) send_bad(g ^ 15'h7fff, i != 3);
        for (int i = 0; i < 9; i++) send_gen(i == 8);
        for (int i = 0; i < 3; i++) send_gen(1'b1);

        $display("[TB] wrong zero words while locked, miss counter clearing");
        send_bad(15'd0, 1'b1);
        exp_pbad = 1'b1;
        send_bad(15'd0, 1'b1);
        send_gen(1'b1);
        for (int i = 0; i < 3; i++) send_bad(g ^ 15'h7fff, 1'b1);
        send_gen(1'b1);
        send_bad(g ^ 15'h7fff, 1'b1);

        $display("[TB] asynchronous reset mid-stream");
        pulse_reset("mid_rst");

        $display("[TB] random vld gaps over a clean stream");
        g = 15'd0;
        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 5));
            send_gen(i >= 8);
        end
        pulse_reset("rst2");

        $display("[TB] dropped word after a zero");
        g = 15'd0;
        for (int i = 0; i < 20; i++) g = gen_prev(g);
        for (int i = 0; i < 22; i++) send_gen(i >= 8);
        g = gen_next(g);
        for (int i = 0; i < 4; i++) begin
            exp_cnt = exp_cnt + 16'd1;
            applyStimulus(g, i != 3, 1'b1);
            g = gen_next(g);
        end
        for (int i = 0; i < 9; i++) send_gen(i == 8);
        send_gen(1'b1);
        pulse_reset("rst3");

        $display("[TB] two full periods locked");
        g = 15'd0;
        for (int i = 0; i < 65546; i++) begin
            if (i == 65536) exp_pok = 1'b1;
            send_gen(i >= 8);
        end
        idle(3);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL sb_drain: got %0d pending records, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
